sc_frog_move_arbiter: RTL
=========================

Name: sc_frog_move_arbiter

Overview:
- Schedules all writes to the frog-position register bank: clear, row load up (load0), row load down (load1), and column shift.
- Arbitrates between player button moves and periodic river "carry" shifts. A carry shift happens when the frog rides a log.
- Each accepted request becomes exactly one single-cycle command to the bank.
- Sits between the button/collision logic and the frog register bank; no other block drives the bank.

Parameters:
- CARRY_PERIOD, 25000000, clock cycles between carry shifts while the frog is on the river (set to 8 in simulation).
- CNT_W, 25, carry timer width; must satisfy 2^CNT_W >= CARRY_PERIOD.
- COOLDOWN, 4, minimum cycles between player commands; used only with the optional feature.

Ports:
- SC_FROGMOVEARB_CLOCK_50  in  1  system clock.
- SC_FROGMOVEARB_RESET_InLow  in  1  reset, synchronous, active-low.
- SC_FROGMOVEARB_StartGame_InLow  in  1  start/restart request.
- SC_FROGMOVEARB_upButton_InLow, _downButton_InLow, _leftButton_InLow, _rightButton_InLow  in  1 each  player buttons, active-low.
- SC_FROGMOVEARB_FirstRow_InLow  in  1  low when the frog is in the bottom row.
- SC_FROGMOVEARB_LeftEdge_InLow, _RightEdge_InLow  in  1 each  low when the frog is in the leftmost or rightmost column.
- SC_FROGMOVEARB_OnRiver_InHigh  in  1  frog is on a log row.
- SC_FROGMOVEARB_CarryDir_In  in  1  log direction: 0 = left, 1 = right.
- SC_FROGMOVEARB_clear_OutLow  out  1  bank clear.
- SC_FROGMOVEARB_load0_OutLow  out  1  move up.
- SC_FROGMOVEARB_load1_OutLow  out  1  move down.
- SC_FROGMOVEARB_shiftselection_Out  out  2  01 = shift left, 10 = shift right, 11 = hold.
- SC_FROGMOVEARB_drop_OutHigh  out  1  one-cycle pulse when a carry would push the frog off the edge.
- SC_FROGMOVEARB_running_OutHigh  out  1  game active.

Behaviour:
- Reset (the only reset; sync, active-low): state IDLE, running=0, carry timer=0, carry_pending=0.
  - clear/load0/load1=1, shiftselection=11, drop=0.
- Outputs are Moore and decoded from registered state. Every command is exactly one cycle wide. Default (non-command) outputs are the reset values.
- States:
  - IDLE: StartGame low -> INIT; all other inputs ignored.
  - INIT: clear=0 for one cycle; running<=1, timer<=0, carry_pending<=0 -> CHECK.
  - CHECK, priority order:
    1. StartGame low -> INIT.
    2. carry_pending -> CARRY.
    3. up -> UP.
    4. down, only if FirstRow_InLow=1 -> DOWN.
    5. left -> LEFT.
    6. right -> RIGHT.
    7. otherwise stay in CHECK.
  - A pressed button that is blocked goes to WAIT_REL with no command: down in the bottom row, left at the left edge, right at the right edge.
  - UP: load0=0. DOWN: load1=0. LEFT: shift=01. RIGHT: shift=10. Each -> WAIT_REL.
  - CARRY: carry_pending<=0.
    - CarryDir=1, RightEdge high: shift=10. CarryDir=1, RightEdge low: no shift, drop=1.
    - CarryDir=0, LeftEdge high: shift=01. CarryDir=0, LeftEdge low: no shift, drop=1.
    - Returns to CHECK, or to WAIT_REL if entered from WAIT_REL (return flag).
  - WAIT_REL: StartGame low -> INIT; carry_pending -> CARRY; all four buttons high -> CHECK; else stay.
    - Enforces one move per press; a held button never repeats.
- Latency: a button seen in CHECK produces its command in the next cycle.
- Carry timer:
  - Counts only while running=1, OnRiver=1 and state is not INIT.
  - Cleared to 0 whenever OnRiver=0.
  - At CARRY_PERIOD-1: wraps to 0 and sets carry_pending.
  - If carry_pending is already set, it stays set; no queueing beyond one pending carry.
- Carry vs button in the same CHECK cycle: carry wins; the button (still held) is served in the following CHECK.
- StartGame low in any running state except mid-command restarts via INIT. A one-cycle command state always completes first.
- Reset mid-command: outputs return to inactive on the next clock edge.

Optional Feature:
- Macro SC_FROGMOVEARB_COOLDOWN_EN.
- Defined:
  - A cooldown counter loads COOLDOWN at every UP/DOWN/LEFT/RIGHT and decrements to 0.
  - CHECK ignores buttons while the counter is nonzero; carry is unaffected.
  - INIT clears the counter.
- Undefined: no counter; a button is accepted on the first CHECK after release.

Test Plan:
- Reset low 2 cycles then high -> all outputs inactive (clear=1, loads=1, shift=11, drop=0, running=0); buttons ignored in IDLE.
- StartGame low 1 cycle -> clear=0 exactly one cycle, running=1. Up held 10 cycles -> load0=0 exactly once, 1 cycle after CHECK; release then press again -> second load0 pulse.
- FirstRow_InLow=0 with down pressed -> no load1 pulse. LeftEdge_InLow=0 with left pressed -> shift stays 11.
- CARRY_PERIOD=8, OnRiver=1, CarryDir=1, RightEdge high -> shift=10 every 8 counted cycles. OnRiver dropped at count 5 -> no carry, timer restarts at 0.
- Carry due while right button is held in WAIT_REL -> carry shift issued, no repeated right move. RightEdge low at carry -> drop=1 for 1 cycle, shift=11.
- With SC_FROGMOVEARB_COOLDOWN_EN and COOLDOWN=4: left pressed 2 cycles after the previous move -> ignored until the counter reaches 0, then one shift=01.

Source files
------------

// File: rtl/sc_frog_move_arbiter.sv
// ---------------------------------------------------------------------------
// sc_frog_move_arbiter
//
// Purpose:
//   Single writer of the frog-position register bank. Player button moves and
//   periodic river "carry" shifts (frog riding a log) are arbitrated here and
//   each accepted request becomes exactly one single-cycle bank command:
//   clear, load0 (row up), load1 (row down) or a column shift.
//
// Parameters:
//   CARRY_PERIOD : clock cycles between carry shifts while on the river
//   CNT_W        : carry timer width, 2**CNT_W >= CARRY_PERIOD
//   COOLDOWN     : minimum cycles between player commands (optional feature)
//
// Optional feature:
//   Define SC_FROGMOVEARB_COOLDOWN_EN to add a player-move cooldown counter.
//   Without it a button is accepted on the first CHECK after release.
//
// Ports:
//   SC_FROGMOVEARB_CLOCK_50             in   system clock
//   SC_FROGMOVEARB_RESET_InLow          in   synchronous active-low reset
//   SC_FROGMOVEARB_StartGame_InLow      in   start / restart request
//   SC_FROGMOVEARB_*Button_InLow        in   up/down/left/right buttons
//   SC_FROGMOVEARB_FirstRow_InLow       in   low when frog is in bottom row
//   SC_FROGMOVEARB_LeftEdge_InLow       in   low when frog is in left column
//   SC_FROGMOVEARB_RightEdge_InLow      in   low when frog is in right column
//   SC_FROGMOVEARB_OnRiver_InHigh       in   frog is on a log row
//   SC_FROGMOVEARB_CarryDir_In          in   log direction, 0 left / 1 right
//   SC_FROGMOVEARB_clear_OutLow         out  bank clear
//   SC_FROGMOVEARB_load0_OutLow         out  move up
//   SC_FROGMOVEARB_load1_OutLow         out  move down
//   SC_FROGMOVEARB_shiftselection_Out   out  01 left, 10 right, 11 hold
//   SC_FROGMOVEARB_drop_OutHigh         out  carry would push frog off edge
//   SC_FROGMOVEARB_running_OutHigh      out  game active
// ---------------------------------------------------------------------------
module sc_frog_move_arbiter #(
    parameter int CARRY_PERIOD = 25000000,
    parameter int CNT_W        = 25,
    parameter int COOLDOWN     = 4
) (
    input  logic       SC_FROGMOVEARB_CLOCK_50,
    input  logic       SC_FROGMOVEARB_RESET_InLow,
    input  logic       SC_FROGMOVEARB_StartGame_InLow,
    input  logic       SC_FROGMOVEARB_upButton_InLow,
    input  logic       SC_FROGMOVEARB_downButton_InLow,
    input  logic       SC_FROGMOVEARB_leftButton_InLow,
    input  logic       SC_FROGMOVEARB_rightButton_InLow,
    input  logic       SC_FROGMOVEARB_FirstRow_InLow,
    input  logic       SC_FROGMOVEARB_LeftEdge_InLow,
    input  logic       SC_FROGMOVEARB_RightEdge_InLow,
    input  logic       SC_FROGMOVEARB_OnRiver_InHigh,
    input  logic       SC_FROGMOVEARB_CarryDir_In,
    output logic       SC_FROGMOVEARB_clear_OutLow,
    output logic       SC_FROGMOVEARB_load0_OutLow,
    output logic       SC_FROGMOVEARB_load1_OutLow,
    output logic [1:0] SC_FROGMOVEARB_shiftselection_Out,
    output logic       SC_FROGMOVEARB_drop_OutHigh,
    output logic       SC_FROGMOVEARB_running_OutHigh
);

    // Elaboration-time parameter sanity check.
    if ((CARRY_PERIOD < 1) || (COOLDOWN < 0) ||
        ((64'd1 << CNT_W) < 64'(CARRY_PERIOD))) begin : g_param_check
        $error("sc_frog_move_arbiter: illegal CARRY_PERIOD/CNT_W/COOLDOWN");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_UP,
        S_DOWN,
        S_LEFT,
        S_RIGHT,
        S_CARRY,
        S_WAIT_REL
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(CARRY_PERIOD - 1);

    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_RIGHT = 2'b10;
    localparam logic [1:0] SH_HOLD  = 2'b11;

    state_t           state_q, state_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pend_q, pend_d;
    logic             ret_q, ret_d;      // CARRY was entered from WAIT_REL
    logic             clear_q, clear_d;
    logic             load0_q, load0_d;
    logic             load1_q, load1_d;
    logic [1:0]       shift_q, shift_d;
    logic             drop_q, drop_d;

    logic btn_up, btn_dn, btn_lf, btn_rt, any_btn, start_req, on_river;
    logic btn_ok;
    logic [1:0] carry_shift;
    logic       carry_drop;

    assign btn_up    = ~SC_FROGMOVEARB_upButton_InLow;
    assign btn_dn    = ~SC_FROGMOVEARB_downButton_InLow;
    assign btn_lf    = ~SC_FROGMOVEARB_leftButton_InLow;
    assign btn_rt    = ~SC_FROGMOVEARB_rightButton_InLow;
    assign any_btn   = btn_up | btn_dn | btn_lf | btn_rt;
    assign start_req = ~SC_FROGMOVEARB_StartGame_InLow;
    assign on_river  = SC_FROGMOVEARB_OnRiver_InHigh;

`ifdef SC_FROGMOVEARB_COOLDOWN_EN
    localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    logic [CD_W-1:0] cd_q, cd_d;

    assign btn_ok = (cd_q == '0);

    always_comb begin
        cd_d = cd_q;
        if (state_q == S_INIT) begin
            cd_d = '0;
        end else if ((state_d == S_UP) || (state_d == S_DOWN) ||
                     (state_d == S_LEFT) || (state_d == S_RIGHT)) begin
            // Loaded on entry so the count starts with the command itself.
            cd_d = CD_LOAD;
        end else if (cd_q != '0) begin
            cd_d = cd_q - CD_W'(1);
        end
    end

    always_ff @(posedge SC_FROGMOVEARB_CLOCK_50) begin
        if (!SC_FROGMOVEARB_RESET_InLow) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end
`else
    assign btn_ok = 1'b1;
`endif

    // Carry outcome is resolved in the cycle the CARRY state is chosen so the
    // command outputs can be registered like every other command.
    always_comb begin
        carry_shift = SH_HOLD;
        carry_drop  = 1'b0;
        if (SC_FROGMOVEARB_CarryDir_In) begin
            if (SC_FROGMOVEARB_RightEdge_InLow) carry_shift = SH_RIGHT;
            else                                carry_drop  = 1'b1;
        end else begin
            if (SC_FROGMOVEARB_LeftEdge_InLow)  carry_shift = SH_LEFT;
            else                                carry_drop  = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            S_IDLE: begin
                if (start_req) state_d = S_INIT;
            end
            S_INIT: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (start_req) begin
                    state_d = S_INIT;
                end else if (pend_q) begin
                    state_d = S_CARRY;
                    ret_d   = 1'b0;
                end else if (btn_ok) begin
                    // Blocked moves still need a release before the next one.
                    if (btn_up) begin
                        state_d = S_UP;
                    end else if (btn_dn) begin
                        state_d = SC_FROGMOVEARB_FirstRow_InLow ? S_DOWN : S_WAIT_REL;
                    end else if (btn_lf) begin
                        state_d = SC_FROGMOVEARB_LeftEdge_InLow ? S_LEFT : S_WAIT_REL;
                    end else if (btn_rt) begin
                        state_d = SC_FROGMOVEARB_RightEdge_InLow ? S_RIGHT : S_WAIT_REL;
                    end
                end
            end
            S_UP, S_DOWN, S_LEFT, S_RIGHT: begin
                state_d = S_WAIT_REL;
            end
            S_CARRY: begin
                state_d = ret_q ? S_WAIT_REL : S_CHECK;
            end
            S_WAIT_REL: begin
                if (start_req) begin
                    state_d = S_INIT;
                end else if (pend_q) begin
                    state_d = S_CARRY;
                    ret_d   = 1'b1;
                end else if (!any_btn) begin
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered command outputs, decoded from the state being entered.
    always_comb begin
        clear_d = (state_d != S_INIT);
        load0_d = (state_d != S_UP);
        load1_d = (state_d != S_DOWN);
        shift_d = SH_HOLD;
        drop_d  = 1'b0;
        case (state_d)
            S_LEFT:  shift_d = SH_LEFT;
            S_RIGHT: shift_d = SH_RIGHT;
            S_CARRY: begin
                shift_d = carry_shift;
                drop_d  = carry_drop;
            end
            default: ;
        endcase
    end

    // Carry timer and single-entry pending flag.
    always_comb begin
        running_d = running_q;
        timer_d   = timer_q;
        pend_d    = pend_q;
        if (state_q == S_INIT) running_d = 1'b1;
        if (state_q == S_CARRY) pend_d = 1'b0;
        if (state_q == S_INIT) begin
            timer_d = '0;
            pend_d  = 1'b0;
        end else if (!on_river) begin
            timer_d = '0;
        end else if (running_q) begin
            if (timer_q == TIMER_LAST) begin
                timer_d = '0;
                pend_d  = 1'b1;
            end else begin
                timer_d = timer_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SC_FROGMOVEARB_CLOCK_50) begin
        if (!SC_FROGMOVEARB_RESET_InLow) begin
            state_q   <= S_IDLE;
            ret_q     <= 1'b0;
            running_q <= 1'b0;
            timer_q   <= '0;
            pend_q    <= 1'b0;
            clear_q   <= 1'b1;
            load0_q   <= 1'b1;
            load1_q   <= 1'b1;
            shift_q   <= SH_HOLD;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            running_q <= running_d;
            timer_q   <= timer_d;
            pend_q    <= pend_d;
            clear_q   <= clear_d;
            load0_q   <= load0_d;
            load1_q   <= load1_d;
            shift_q   <= shift_d;
            drop_q    <= drop_d;
        end
    end

    assign SC_FROGMOVEARB_clear_OutLow       = clear_q;
    assign SC_FROGMOVEARB_load0_OutLow       = load0_q;
    assign SC_FROGMOVEARB_load1_OutLow       = load1_q;
    assign SC_FROGMOVEARB_shiftselection_Out = shift_q;
    assign SC_FROGMOVEARB_drop_OutHigh       = drop_q;
    assign SC_FROGMOVEARB_running_OutHigh    = running_q;

endmodule
